// File: rtl/pic_mem_fetch_pkg.sv
// rtl/pic_mem_fetch_pkg.sv - shared constants and types for the sprite fetch engine
package pic_mem_fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int PIX_W  = 16;
    localparam int DIM_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        tag_t             tag;
        logic [PIX_W-1:0] data;
    } stream_word_t;

endpackage

// File: rtl/pic_fetch_fifo.sv
// rtl/pic_fetch_fifo.sv - 2-entry synchronous FIFO of tagged pixel words
module pic_fetch_fifo
    import pic_mem_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  stream_word_t push_word,
    input  logic         pop,
    output stream_word_t head_word,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    stream_word_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_word = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pic_mem_fetch.sv
// rtl/pic_mem_fetch.sv - sprite read engine streaming RGB565 pixels from picture memory port 2
module pic_mem_fetch
    import pic_mem_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    input  logic [PIX_W-1:0]  mem_readdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    state_t            state;
    state_t            state_n;
    logic [DIM_W-1:0]  width_r;
    logic [DIM_W-1:0]  height_r;
    logic [ADDR_W-1:0] stride_r;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] col_addr;
    logic [ADDR_W-1:0] next_row_addr;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic              inflight;
    tag_t              inflight_tag;
    tag_t              issue_tag;
    logic              issue;
    logic              pop;
    logic [2:0]        occupancy;
    logic              drain_done;
    stream_word_t      head_word;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_address    = col_addr;
    assign mem_chipselect = issue;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_FIN);

    assign pix_valid = !fifo_empty;
    assign pix_data  = head_word.data;
    assign pix_sof   = head_word.tag.sof;
    assign pix_eol   = head_word.tag.eol;
    assign pix_eof   = head_word.tag.eof;
    assign pop       = pix_valid && pix_ready;

    // Words held or owed: a read may go out only if the FIFO will have room when it lands.
    assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue         = (state == ST_FETCH) && (occupancy < (3'd2 + {2'b00, pop}));
    assign next_row_addr = row_addr + stride_r;

    assign issue_tag.sof = (row == '0) && (col == '0);
    assign issue_tag.eol = (col == width_r - 7'd1);
    assign issue_tag.eof = issue_tag.eol && (row == height_r - 7'd1);

    // Last pixel leaves this cycle or already left, and nothing is still on its way back.
    assign drain_done = !inflight && (fifo_empty || ((fifo_count == 2'd1) && pop));

    pic_fetch_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_word ({inflight_tag, mem_readdata}),
        .pop       (pop),
        .head_word (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: empty sprites skip straight to FIN, the eof read ends FETCH.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ((width == '0) || (height == '0)) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue && issue_tag.eof) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Command latch, address walker and the one-deep in-flight read tracker.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            width_r      <= '0;
            height_r     <= '0;
            stride_r     <= '0;
            row_addr     <= '0;
            col_addr     <= '0;
            col          <= '0;
            row          <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                width_r  <= width;
                height_r <= height;
                stride_r <= stride;
                row_addr <= base_addr;
                col_addr <= base_addr;
                col      <= '0;
                row      <= '0;
            end else if (issue) begin
                if (issue_tag.eol) begin
                    row_addr <= next_row_addr;
                    col_addr <= next_row_addr;
                    col      <= '0;
                    row      <= row + 7'd1;
                end else begin
                    col_addr <= col_addr + 12'd1;
                    col      <= col + 7'd1;
                end
            end
            inflight     <= issue;
            inflight_tag <= issue_tag;
        end
    end

endmodule

// File: tb/tb_pic_mem_fetch.sv
// tb/tb_pic_mem_fetch.sv - self-checking bench for pic_mem_fetch
module tb_pic_mem_fetch;
    import pic_mem_fetch_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [DIM_W-1:0]  width = '0;
    logic [DIM_W-1:0]  height = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [PIX_W-1:0]  mem_readdata = '0;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int hs_cyc = 0;
    int outst = 0;
    logic hs_expected = 1'b0;

    logic [18:0] exp_pix[$];
    logic [11:0] exp_addr[$];
    logic [18:0] got[$];
    int          got_cyc[$];
    logic        prev_stall = 1'b0;
    logic [18:0] prev_word = '0;
    logic [18:0] cur_word;
    logic [18:0] lit;

    pic_mem_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .width          (width),
        .height         (height),
        .stride         (stride),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .pix_eof        (pix_eof)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency holding word[i] = i.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= {4'h0, mem_address};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready pattern: 0 always ready, 1 repeats 1,0,0,1, 2 never ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: pix_ready = 1'b0;
        endcase
    end

    function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    // Reference sprite walk: row-major, addresses modulo 4096, data equals address.
    task automatic model_cmd(input logic [11:0] b, input int w, input int h, input logic [11:0] s);
        logic [11:0] a;
        logic        sof, eol, eof;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a   = 12'(b + r * s + c);
                sof = (r == 0) && (c == 0);
                eol = (c == w - 1);
                eof = eol && (r == h - 1);
                exp_addr.push_back(a);
                exp_pix.push_back({sof, eol, eof, 4'h0, a});
            end
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the reference queues.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_pix.delete();
            exp_addr.delete();
            prev_stall = 1'b0;
            outst = 0;
        end else begin
            cur_word = {pix_sof, pix_eol, pix_eof, pix_data};
            check("tie_clken", {31'd0, mem_clken}, 32'd1);
            check("tie_write", {31'd0, mem_write}, 32'd0);
            if (prev_stall) begin
                check("stall_valid", {31'd0, pix_valid}, 32'd1);
                check("stall_word", {13'd0, cur_word}, {13'd0, prev_word});
            end
            if (mem_chipselect) begin
                check("read_expected", {31'd0, exp_addr.size() > 0}, 32'd1);
                if (exp_addr.size() > 0) check("read_addr", {20'd0, mem_address}, {20'd0, exp_addr.pop_front()});
                outst++;
            end
            if (pix_valid && pix_ready) begin
                check("pixel_expected", {31'd0, exp_pix.size() > 0}, 32'd1);
                if (exp_pix.size() > 0) check("pixel", {13'd0, cur_word}, {13'd0, exp_pix.pop_front()});
                got.push_back(cur_word);
                got_cyc.push_back(cyc);
                hs_cyc = cyc;
                outst--;
            end
            if (mem_chipselect) check("outstanding_le2", {31'd0, outst <= 2}, 32'd1);
            prev_stall = pix_valid && !pix_ready;
            prev_word  = cur_word;
            if (done) begin
                done_cnt++;
                check("done_all_pixels", exp_pix.size(), 0);
                if (hs_expected) check("done_latency", cyc - hs_cyc, 1);
            end
        end
    end

    task automatic start_cmd(input logic [11:0] b, input int w, input int h, input logic [11:0] s, input logic model);
        @(posedge clk); #2;
        base_addr = b;
        width     = 7'(w);
        height    = 7'(h);
        stride    = s;
        start     = 1'b1;
        if (model) begin
            got.delete();
            got_cyc.delete();
            hs_expected = (w != 0) && (h != 0);
            model_cmd(b, w, h, s);
        end
        @(posedge clk); #2;
        start     = 1'b0;
        base_addr = 12'hABC;
        width     = 7'd3;
        height    = 7'd9;
        stride    = 12'h777;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int d0;
        int busy_cnt;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int busy_cnt;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        check("rst_addr", {20'd0, mem_address}, 32'd0);

        // Basic 4x2 sprite at full rate.
        ready_mode = 0;
        d0 = done_cnt;
        start_cmd(12'h010, 4, 2, 12'd8, 1'b1);
        wait_done(d0, 100);
        check("t1_count", got.size(), 8);
        lit = {3'b100, 16'h0010}; check("t1_first", {13'd0, got[0]}, {13'd0, lit});
        lit = {3'b010, 16'h0013}; check("t1_eol4", {13'd0, got[3]}, {13'd0, lit});
        lit = {3'b000, 16'h0018}; check("t1_row2", {13'd0, got[4]}, {13'd0, lit});
        lit = {3'b011, 16'h001B}; check("t1_last", {13'd0, got[7]}, {13'd0, lit});
        check("t1_rate", got_cyc[7] - got_cyc[0], 7);

        // Same sprite under 1,0,0,1 backpressure.
        ready_mode = 1;
        d0 = done_cnt;
        start_cmd(12'h010, 4, 2, 12'd8, 1'b1);
        wait_done(d0, 200);
        check("t2_count", got.size(), 8);
        lit = {3'b000, 16'h0019}; check("t2_px5", {13'd0, got[5]}, {13'd0, lit});

        // Address wrap 0xFFE..0x001.
        ready_mode = 0;
        d0 = done_cnt;
        start_cmd(12'hFFE, 4, 1, 12'd4, 1'b1);
        wait_done(d0, 100);
        lit = {3'b100, 16'h0FFE}; check("t3_px0", {13'd0, got[0]}, {13'd0, lit});
        lit = {3'b000, 16'h0FFF}; check("t3_px1", {13'd0, got[1]}, {13'd0, lit});
        lit = {3'b000, 16'h0000}; check("t3_px2", {13'd0, got[2]}, {13'd0, lit});
        lit = {3'b011, 16'h0001}; check("t3_px3", {13'd0, got[3]}, {13'd0, lit});

        // Empty sprite: one busy cycle carrying the done pulse, no reads or pixels.
        d0 = done_cnt;
        busy_cnt = 0;
        start_cmd(12'h100, 0, 5, 12'd8, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("t4_busy_cycles", busy_cnt, 1);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_no_pixels", got.size(), 0);

        // Single pixel, with a second start while busy that must be ignored.
        d0 = done_cnt;
        start_cmd(12'h123, 1, 1, 12'd0, 1'b1);
        start_cmd(12'h200, 2, 2, 12'd4, 1'b0);
        wait_done(d0, 100);
        repeat (5) @(posedge clk);
        check("t5_count", got.size(), 1);
        lit = {3'b111, 16'h0123}; check("t5_px", {13'd0, got[0]}, {13'd0, lit});
        check("t5_one_done", done_cnt - d0, 1);

        // Reset mid-fetch with the consumer stalled, then a clean restart.
        ready_mode = 2;
        d0 = done_cnt;
        start_cmd(12'h010, 4, 2, 12'd8, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        check("t6_valid_before", {31'd0, pix_valid}, 32'd1);
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);
        check("t6_busy_after", {31'd0, busy}, 32'd0);
        check("t6_valid_after", {31'd0, pix_valid}, 32'd0);
        check("t6_done_after", {31'd0, done}, 32'd0);
        repeat (4) @(posedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        ready_mode = 0;
        d0 = done_cnt;
        start_cmd(12'h040, 2, 2, 12'h010, 1'b1);
        wait_done(d0, 100);
        check("t6_count", got.size(), 4);
        lit = {3'b100, 16'h0040}; check("t6_first", {13'd0, got[0]}, {13'd0, lit});
        lit = {3'b011, 16'h0051}; check("t6_last", {13'd0, got[3]}, {13'd0, lit});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
